// File: rtl/eb_subtractor_pipe.sv
// Two-stage pipelined 8-bit subtractor: stage 1 resolves the low nibble and its borrow,
// stage 2 resolves the high nibble plus borrow-out, signed overflow and zero flags.
module eb_subtractor_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] d,
    output logic       bout,
    output logic       ovf,
    output logic       zero
);

    // 4-bit borrow-lookahead slice; returns {borrow_out, difference}.
    function automatic logic [4:0] nibble_sub(input logic [3:0] x, input logic [3:0] y,
                                              input logic bi);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] br;
        g     = ~x & y;
        p     = ~(x ^ y);
        br[0] = bi;
        br[1] = g[0] | (p[0] & bi);
        br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
        br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
        br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bi);
        return {br[4], x ^ y ^ br[3:0]};
    endfunction

    logic       s1_v;
    logic [3:0] s1_dlo;
    logic       s1_b4;
    logic [3:0] s1_ahi;
    logic [3:0] s1_bhi;
    logic       s2_v;

    logic       s1_adv;
    logic       s2_adv;
    logic       accept;
    logic [4:0] lo_res;
    logic [4:0] hi_res;
    logic [7:0] d_next;
    logic       ovf_next;

    assign s2_adv    = !s2_v | out_ready;
    assign s1_adv    = !s1_v | s2_adv;
    assign in_ready  = s1_adv;
    assign accept    = in_valid & s1_adv;
    assign out_valid = s2_v;

    assign lo_res   = nibble_sub(a[3:0], b[3:0], bin);
    assign hi_res   = nibble_sub(s1_ahi, s1_bhi, s1_b4);
    assign d_next   = {hi_res[3:0], s1_dlo};
    assign ovf_next = (s1_ahi[3] != s1_bhi[3]) && (d_next[7] != s1_ahi[3]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_dlo <= 4'h0;
            s1_b4  <= 1'b0;
            s1_ahi <= 4'h0;
            s1_bhi <= 4'h0;
        end else if (accept) begin
            s1_v   <= 1'b1;
            s1_dlo <= lo_res[3:0];
            s1_b4  <= lo_res[4];
            s1_ahi <= a[7:4];
            s1_bhi <= b[7:4];
        end else if (s1_adv) begin
            s1_v <= 1'b0;
        end
    end

    // Data only reloads when a real beat moves in, so idle outputs keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v <= 1'b0;
            d    <= 8'h00;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                d    <= d_next;
                bout <= hi_res[4];
                ovf  <= ovf_next;
                zero <= (d_next == 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_eb_subtractor_pipe.sv
// Scoreboard bench for eb_subtractor_pipe: the driver pushes arithmetic-model results,
// an independent monitor compares every presented output beat in order.
module tb_eb_subtractor_pipe;

    typedef struct packed {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
        logic       zero;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
    logic       zero;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];
    logic rand_ready_on = 1'b0;

    eb_subtractor_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, signed overflow from the representable range.
    function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic bi);
        int   u;
        int   s;
        res_t r;
        u = int'(x) - int'(y) - int'(bi);
        s = int'($signed(x)) - int'($signed(y)) - int'(bi);
        r.d    = 8'(u & 255);
        r.bout = (u < 0);
        r.ovf  = (s < -128) || (s > 127);
        r.zero = ((u & 255) == 0);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic bi,
                                 output int waited);
        bit done;
        done     = 0;
        waited   = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        bin      = bi;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                sb.push_back(model(x, y, bi));
            end else begin
                waited++;
                if (waited > 200) begin
                    checkOutput("accept_timeout", 32'(waited), 32'd0);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every presented beat must match the queue head; it is popped only when consumed.
    initial begin
        res_t exp_r;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", 32'({d, bout, ovf, zero}), 32'hFFFF_FFFF);
                end else begin
                    exp_r = sb[0];
                    checkOutput("result", 32'({d, bout, ovf, zero}), 32'(exp_r));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_on) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int k;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbi;

        rst = 1'b1;
        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_outputs", 32'({d, bout, ovf, zero}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Latency: visible after the second edge following the accept.
        applyStimulus(8'd115, 8'd15, 1'b0, w);
        checkOutput("lat_edge1_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_edge2_valid", 32'(out_valid), 32'd1);
        checkOutput("lat_d", 32'(d), 32'd100);
        waitDrain();

        applyStimulus(8'd15, 8'd115, 1'b0, w);
        applyStimulus(8'd200, 8'd15, 1'b0, w);
        applyStimulus(8'h80, 8'h01, 1'b0, w);
        applyStimulus(8'h00, 8'h00, 1'b1, w);
        applyStimulus(8'h5A, 8'h5A, 1'b0, w);
        applyStimulus(8'hFF, 8'hFF, 1'b1, w);
        applyStimulus(8'h7F, 8'hFF, 1'b0, w);
        waitDrain();

        // Back-to-back random stream must be accepted every cycle.
        for (int i = 0; i < 16; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rbi = 1'($urandom);
            applyStimulus(ra, rb, rbi, w);
            checkOutput("stream_no_stall", 32'(w), 32'd0);
        end
        waitDrain();

        // Backpressure: capacity of two, third beat held until out_ready rises.
        out_ready = 1'b0;
        applyStimulus(8'd10, 8'd3, 1'b0, w);
        applyStimulus(8'd20, 8'd4, 1'b0, w);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        a = 8'd30;
        b = 8'd5;
        bin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall_d", 32'(d), 32'd7);
        out_ready = 1'b1;
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(8'd30, 8'd5, 1'b0, w);
        waitDrain();

        // Random stimulus under random backpressure.
        rand_ready_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rbi = 1'($urandom);
            applyStimulus(ra, rb, rbi, w);
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        rand_ready_on = 1'b0;
        #1;
        out_ready = 1'b1;
        waitDrain();

        // Reset with two beats in flight discards them.
        out_ready = 1'b0;
        applyStimulus(8'd50, 8'd1, 1'b0, w);
        applyStimulus(8'd60, 8'd2, 1'b0, w);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_outputs", 32'({d, bout, ovf, zero}), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_idle", 32'(out_valid), 32'd0);
        applyStimulus(8'd9, 8'd9, 1'b0, w);
        @(posedge clk);
        #1;
        checkOutput("post_reset_zero", 32'({d, zero}), 32'({8'h00, 1'b1}));
        waitDrain();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
